// File: rtl/usd_apu_bridge_pkg.sv
// Shared types, field offsets and defaults for the uSD host-side bridge.
package usd_pkg;

    localparam int unsigned DEF_WORDS_PER_BLOCK = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 2000000;
    localparam int unsigned DEF_CNT_W           = 14;

    localparam int unsigned IDX_W   = 6;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned BLK_W   = 8;
    localparam int unsigned ARG_W   = 32;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CMD_W   = 72;
    localparam int unsigned RES_W   = 36;

    // Command-word field positions
    localparam int unsigned CMD_IDX_LSB = 58;
    localparam int unsigned TYPE_LSB    = 56;
    localparam int unsigned BLK_LSB     = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_WAIT,
        ST_RCAP,
        ST_RD,
        ST_RDCAP,
        ST_RDH
    } state_t;

    typedef enum logic [1:0] {
        TYPE_NONE  = 2'b00,
        TYPE_WRITE = 2'b01,
        TYPE_READ  = 2'b10,
        TYPE_RSVD  = 2'b11
    } req_type_t;

    // Assemble one command-FIFO word; the unused middle field stays zero
    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [BLK_W-1:0]  blocks,
        input logic [IDX_W-1:0]  idx,
        input logic [TYPE_W-1:0] typ,
        input logic [ARG_W-1:0]  arg
    );
        logic [CMD_W-1:0] word;
        word = '0;
        word[BLK_LSB +: BLK_W]       = blocks;
        word[CMD_IDX_LSB +: IDX_W]   = idx;
        word[TYPE_LSB +: TYPE_W]     = typ;
        word[ARG_W-1:0]              = arg;
        return word;
    endfunction

endpackage

// File: rtl/usd_apu_bridge_if.sv
// Host request/data/response and FIFO-side signals of the uSD bridge.
interface usd_apu_bridge_if;
    import usd_pkg::*;

    logic                reqValid;
    logic                reqReady;
    logic [IDX_W-1:0]    reqCmdIdx;
    logic [TYPE_W-1:0]   reqType;
    logic [BLK_W-1:0]    reqBlocks;
    logic [ARG_W-1:0]    reqArg;
    logic [DATA_W-1:0]   wrData;
    logic                wrValid;
    logic                wrReady;
    logic [DATA_W-1:0]   rdData;
    logic                rdValid;
    logic                rdReady;
    logic                rspValid;
    logic [RES_W-1:0]    rspStatus;
    logic                rspTimeout;
    logic                busy;
    logic [CMD_W-1:0]    cmdFifoData;
    logic                cmdFifoWrEn;
    logic                cmdRdyRd;
    logic [CMD_W-1:0]    cmdDataFifoData;
    logic                cmdDataFifoWrEn;
    logic                cmdRdyWr;
    logic [RES_W-1:0]    resultFifoData;
    logic                resultFifoRdEn;
    logic                resultPending;
    logic [CMD_W-1:0]    resultDataFifoData;
    logic                resultDataFifoRdEn;
    logic                readDataAvail;

    // Bridge side
    modport slave (
        input  reqValid, reqCmdIdx, reqType, reqBlocks, reqArg,
        input  wrData, wrValid, rdReady,
        input  cmdRdyRd, cmdRdyWr, resultFifoData, resultPending,
        input  resultDataFifoData, readDataAvail,
        output reqReady, wrReady, rdData, rdValid,
        output rspValid, rspStatus, rspTimeout, busy,
        output cmdFifoData, cmdFifoWrEn, cmdDataFifoData, cmdDataFifoWrEn,
        output resultFifoRdEn, resultDataFifoRdEn
    );

    // Host plus FIFO environment side
    modport master (
        output reqValid, reqCmdIdx, reqType, reqBlocks, reqArg,
        output wrData, wrValid, rdReady,
        output cmdRdyRd, cmdRdyWr, resultFifoData, resultPending,
        output resultDataFifoData, readDataAvail,
        input  reqReady, wrReady, rdData, rdValid,
        input  rspValid, rspStatus, rspTimeout, busy,
        input  cmdFifoData, cmdFifoWrEn, cmdDataFifoData, cmdDataFifoWrEn,
        input  resultFifoRdEn, resultDataFifoRdEn
    );

endinterface

// File: rtl/usd_apu_bridge_timeout_cnt.sv
// Clear/enable cycle counter with a terminal flag at LIMIT-1 (watchdog building block).
module usd_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term_c
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_cnt;

    assign o_term_c = (r_cnt == W'(LIMIT - 1));

    // Count enabled cycles, saturating at the terminal value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_term_c) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/usd_apu_bridge.sv
// Host-side command sequencer: one request -> command word, optional write/read data phase, result.
module usd_apu_bridge
    import usd_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             apuClk,
    input  logic             sysRst,
    usd_apu_bridge_if.slave  bif
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [IDX_W-1:0]    r_cmd_idx;
    logic [TYPE_W-1:0]   r_type;
    logic [BLK_W-1:0]    r_blocks;
    logic [ARG_W-1:0]    r_arg;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_req_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic                r_rsp_timeout;
    logic [RES_W-1:0]    r_rsp_status;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_accept;
    logic                w_last;
    logic                w_cmd_wr_en;
    logic                w_wr_ready;
    logic                w_wr_fire;
    logic                w_res_rd_en;
    logic                w_rdat_rd_en;
    logic                w_rd_take;
    logic                w_rsp_fire;
    logic                w_to_fire;
    logic                w_to_term;
    logic                w_unused;

    assign w_accept = bif.reqValid & r_req_ready;
    assign w_last   = (r_cnt == CNT_W'(1));
    assign w_unused = ^bif.resultDataFifoData[CMD_W-1:DATA_W];

    // Result-wait watchdog, restarted every time WAIT is entered
    usd_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (apuClk),
        .rst      (sysRst),
        .i_clr    (r_state != ST_WAIT),
        .i_en     (r_state == ST_WAIT),
        .o_term_c (w_to_term)
    );

    // State register
    always_ff @(posedge apuClk or posedge sysRst) begin
        if (sysRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and same-cycle FIFO/host strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_wr_en  = 1'b0;
        w_wr_ready   = 1'b0;
        w_wr_fire    = 1'b0;
        w_res_rd_en  = 1'b0;
        w_rdat_rd_en = 1'b0;
        w_rd_take    = 1'b0;
        w_rsp_fire   = 1'b0;
        w_to_fire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bif.cmdRdyRd) begin
                    w_cmd_wr_en = 1'b1;
                    w_state_nxt = ((r_type == TYPE_WRITE) && (r_cnt != '0)) ? ST_WR : ST_WAIT;
                end
            end
            ST_WR: begin
                w_wr_ready = ~bif.cmdRdyWr;
                if (w_wr_ready && bif.wrValid) begin
                    w_wr_fire = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bif.resultPending) begin
                    w_res_rd_en = 1'b1;
                    w_state_nxt = ST_RCAP;
                end else if (w_to_term) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RCAP: begin
                if ((r_type == TYPE_READ) && (r_cnt != '0)) begin
                    w_state_nxt = ST_RD;
                end else begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD: begin
                if (bif.readDataAvail && !r_rd_valid) begin
                    w_rdat_rd_en = 1'b1;
                    w_state_nxt  = ST_RDCAP;
                end
            end
            ST_RDCAP: begin
                w_state_nxt = ST_RDH;
            end
            ST_RDH: begin
                if (bif.rdReady) begin
                    w_rd_take = 1'b1;
                    if (w_last) begin
                        w_rsp_fire  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch and remaining data-word count
    always_ff @(posedge apuClk or posedge sysRst) begin
        if (sysRst) begin
            r_cmd_idx <= '0;
            r_type    <= '0;
            r_blocks  <= '0;
            r_arg     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_cmd_idx <= bif.reqCmdIdx;
            r_type    <= bif.reqType;
            r_blocks  <= bif.reqBlocks;
            r_arg     <= bif.reqArg;
            if ((bif.reqType == TYPE_WRITE) || (bif.reqType == TYPE_READ)) begin
                r_cnt <= CNT_W'(32'(bif.reqBlocks) * WORDS_PER_BLOCK);
            end else begin
                r_cnt <= '0;
            end
        end else if (w_wr_fire || w_rd_take) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Handshake flags and result reporting
    always_ff @(posedge apuClk or posedge sysRst) begin
        if (sysRst) begin
            r_req_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_status  <= '0;
        end else begin
            r_req_ready   <= (w_state_nxt == ST_IDLE);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_rsp_valid   <= w_rsp_fire | w_to_fire;
            r_rsp_timeout <= w_to_fire;
            if (w_to_fire) begin
                r_rsp_status <= '0;
            end else if (r_state == ST_RCAP) begin
                r_rsp_status <= bif.resultFifoData;
            end
        end
    end

    // Read-data holding register toward the host
    always_ff @(posedge apuClk or posedge sysRst) begin
        if (sysRst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (r_state == ST_RDCAP) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= bif.resultDataFifoData[DATA_W-1:0];
        end else if (w_rd_take) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign bif.reqReady           = r_req_ready;
    assign bif.busy               = r_busy;
    assign bif.rspValid           = r_rsp_valid;
    assign bif.rspTimeout         = r_rsp_timeout;
    assign bif.rspStatus          = r_rsp_status;
    assign bif.rdValid            = r_rd_valid;
    assign bif.rdData             = r_rd_data;
    assign bif.cmdFifoData        = pack_cmd(r_blocks, r_cmd_idx, r_type, r_arg);
    assign bif.cmdFifoWrEn        = w_cmd_wr_en;
    assign bif.wrReady            = w_wr_ready;
    assign bif.cmdDataFifoWrEn    = w_wr_fire;
    assign bif.cmdDataFifoData    = w_wr_fire ? {8'h00, bif.wrData} : '0;
    assign bif.resultFifoRdEn     = w_res_rd_en;
    assign bif.resultDataFifoRdEn = w_rdat_rd_en;

endmodule

// File: tb/tb_usd_apu_bridge.sv
// Directed bench for usd_apu_bridge with small FIFO-side models and a strobe monitor.
module tb_usd_apu_bridge;

    logic clk    = 1'b0;
    logic sysRst = 1'b1;

    usd_apu_bridge_if bif ();

    usd_apu_bridge #(
        .WORDS_PER_BLOCK (64),
        .TIMEOUT_CYCLES  (100),
        .CNT_W           (14)
    ) dut (
        .apuClk (clk),
        .sysRst (sysRst),
        .bif    (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int n_cmd = 0;
    int n_res_rd = 0;
    int n_rdat_rd = 0;
    int n_rsp = 0;
    int cmd_cyc = 0;
    int rsp_cyc = 0;
    int rsp_rd_cnt = 0;
    logic [71:0] last_cmd = '0;
    logic [35:0] last_status = '0;
    logic        last_to = 1'b0;
    logic [71:0] got_wr[$];
    logic [63:0] got_rd[$];
    logic [63:0] rd_q[$];
    logic        hold_pending = 1'b0;
    logic [63:0] hold_data = '0;
    logic        pend_res = 1'b0;
    logic        pend_rd = 1'b0;
    logic [35:0] res_word = '0;
    bit          rd_gate_en = 1'b0;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkword(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 7)};
    endfunction

    function automatic logic [63:0] mkrd(input int i);
        return {32'hBEEF_0000 + 32'(i), 32'h5A5A_5A5A ^ 32'(i)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!sysRst) begin
            if (bif.cmdFifoWrEn) begin
                n_cmd++;
                last_cmd = bif.cmdFifoData;
                cmd_cyc  = cyc;
            end
            if (bif.cmdDataFifoWrEn) got_wr.push_back(bif.cmdDataFifoData);
            if (bif.resultFifoRdEn) n_res_rd++;
            if (bif.resultDataFifoRdEn) n_rdat_rd++;
            if (bif.rspValid) begin
                n_rsp++;
                last_status = bif.rspStatus;
                last_to     = bif.rspTimeout;
                rsp_cyc     = cyc;
                rsp_rd_cnt  = got_rd.size();
            end
            if (bif.cmdRdyWr) begin
                chk("stall_wrready", 72'(bif.wrReady), 72'd0);
                chk("stall_strobe", 72'(bif.cmdDataFifoWrEn), 72'd0);
            end
            if (hold_pending) begin
                chk("rd_hold_valid", 72'(bif.rdValid), 72'd1);
                chk("rd_hold_data", 72'(bif.rdData), 72'(hold_data));
            end
            if (bif.rdValid && bif.rdReady) got_rd.push_back(bif.rdData);
            hold_pending = bif.rdValid && !bif.rdReady;
            hold_data    = bif.rdData;
        end
        pend_res = bif.resultFifoRdEn;
        pend_rd  = bif.resultDataFifoRdEn;
    end

    // Non-FWFT FIFO models: dout changes the cycle after the read strobe
    always @(posedge clk) begin
        #1;
        if (pend_res) begin
            bif.resultFifoData = res_word;
            bif.resultPending  = 1'b0;
        end
        if (pend_rd && (rd_q.size() > 0)) bif.resultDataFifoData = {8'hEE, rd_q.pop_front()};
        bif.readDataAvail = (rd_q.size() > 0) && (!rd_gate_en || ($urandom_range(0, 2) != 0));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [5:0] idx, input logic [1:0] typ,
                          input logic [7:0] blk, input logic [31:0] arg);
        int b = 0;
        while (!bif.reqReady && b < 200) begin
            step(1);
            b++;
        end
        chk("req_ready_wait", 72'(bif.reqReady), 72'd1);
        bif.reqValid  = 1'b1;
        bif.reqCmdIdx = idx;
        bif.reqType   = typ;
        bif.reqBlocks = blk;
        bif.reqArg    = arg;
        step(1);
        bif.reqValid  = 1'b0;
        bif.reqCmdIdx = 6'h3F;
        bif.reqType   = 2'b11;
        bif.reqBlocks = 8'hFF;
        bif.reqArg    = 32'hFFFF_FFFF;
    endtask

    task automatic wait_rsp(input int base, input int budget, input string tag);
        int b = 0;
        while (n_rsp == base && b < budget) begin
            step(1);
            b++;
        end
        chk(tag, 72'(n_rsp != base), 72'd1);
    endtask

    // Offer n host words; optionally assert back-pressure for 5 cycles once word stall_at is next
    task automatic feed(input int n, input int stall_at, output bit ok);
        int  idx = 0;
        int  budget = 0;
        int  stall_left = 0;
        bit  stalled = 1'b0;
        bit  fire;
        ok = 1'b1;
        while (idx < n && ok) begin
            if (!stalled && stall_at >= 0 && idx == stall_at) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            bif.cmdRdyWr = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            bif.wrValid = 1'b1;
            bif.wrData  = mkword(idx);
            @(negedge clk);
            fire = bif.wrValid && bif.wrReady;
            step(1);
            if (fire) idx++;
            budget++;
            if (budget > 2000) ok = 1'b0;
        end
        bif.wrValid  = 1'b0;
        bif.cmdRdyWr = 1'b0;
    endtask

    task automatic run_write(input int stall_at, input logic [35:0] st, input string tag);
        int s0;
        bit ok;
        s0 = n_rsp;
        got_wr.delete();
        do_req(6'd24, 2'b01, 8'd1, 32'h0000_1000);
        feed(64, stall_at, ok);
        chk({tag, "_feed_done"}, 72'(ok), 72'd1);
        step(4);
        chk({tag, "_strobes"}, 72'(got_wr.size()), 72'd64);
        for (int i = 0; i < 64 && i < int'(got_wr.size()); i++)
            chk($sformatf("%s_w%0d", tag, i), got_wr[i], {8'h00, mkword(i)});
        chk({tag, "_cmd_word"}, last_cmd, 72'h01_61_00000000001000);
        res_word = st;
        bif.resultPending = 1'b1;
        wait_rsp(s0, 50, {tag, "_rsp_seen"});
        chk({tag, "_status"}, 72'(last_status), 72'(st));
        chk({tag, "_timeout_flag"}, 72'(last_to), 72'd0);
    endtask

    initial begin
        int n0, r0, s0, d0;
        bit ok;
        int stall;
        bit stalled;
        int b;

        bif.reqValid = 1'b0;  bif.reqCmdIdx = '0;  bif.reqType = '0;
        bif.reqBlocks = '0;   bif.reqArg = '0;     bif.wrData = '0;
        bif.wrValid = 1'b0;   bif.rdReady = 1'b1;  bif.cmdRdyRd = 1'b1;
        bif.cmdRdyWr = 1'b0;  bif.resultPending = 1'b0;
        bif.resultFifoData = 36'hF_DEAD_BEEF;
        bif.resultDataFifoData = 72'hEE_FFFF_FFFF_FFFF_FFFF;
        bif.readDataAvail = 1'b0;

        // Reset values
        #1;
        chk("rst_req_ready", 72'(bif.reqReady), 72'd0);
        chk("rst_busy", 72'(bif.busy), 72'd0);
        chk("rst_cmd_wr_en", 72'(bif.cmdFifoWrEn), 72'd0);
        chk("rst_cmd_data", bif.cmdFifoData, 72'd0);
        chk("rst_rd_valid", 72'(bif.rdValid), 72'd0);
        chk("rst_rsp_valid", 72'(bif.rspValid), 72'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sysRst = 1'b0;
        #1;
        chk("rdy_before_edge", 72'(bif.reqReady), 72'd0);
        step(1);
        chk("rdy_after_edge", 72'(bif.reqReady), 72'd1);

        // CMD0, no data, command FIFO full for 3 cycles
        n0 = n_cmd; r0 = n_res_rd; s0 = n_rsp;
        bif.cmdRdyRd = 1'b0;
        do_req(6'd0, 2'b00, 8'd0, 32'h0);
        chk("cmd0_busy", 72'(bif.busy), 72'd1);
        step(3);
        chk("cmd0_hold", 72'(n_cmd - n0), 72'd0);
        bif.cmdRdyRd = 1'b1;
        res_word = 36'h0_0000_0120;
        step(10);
        bif.resultPending = 1'b1;
        wait_rsp(s0, 50, "cmd0_rsp_seen");
        step(3);
        chk("cmd0_cmd_cnt", 72'(n_cmd - n0), 72'd1);
        chk("cmd0_cmd_word", last_cmd, 72'h0);
        chk("cmd0_res_rd_cnt", 72'(n_res_rd - r0), 72'd1);
        chk("cmd0_rsp_cnt", 72'(n_rsp - s0), 72'd1);
        chk("cmd0_status", 72'(last_status), 72'h120);
        chk("cmd0_timeout_flag", 72'(last_to), 72'd0);
        chk("cmd0_ready_after", 72'(bif.reqReady), 72'd1);

        // CMD24 single-block write, then again with back-pressure mid-block
        run_write(-1, 36'h0_0000_0900, "wr");
        run_write(20, 36'h0_0000_0A05, "wrbp");

        // CMD17 two-block read with gated availability and a host stall
        got_rd.delete();
        for (int i = 0; i < 128; i++) rd_q.push_back(mkrd(i));
        rd_gate_en = 1'b1;
        d0 = n_rdat_rd; s0 = n_rsp;
        do_req(6'd17, 2'b10, 8'd2, 32'h0000_0200);
        step(5);
        res_word = 36'h9_0000_0900;
        bif.resultPending = 1'b1;
        stall = 0; stalled = 1'b0; b = 0;
        while (n_rsp == s0 && b < 3000) begin
            if (!stalled && got_rd.size() == 50 && bif.rdValid) begin
                bif.rdReady = 1'b0;
                stall = 2;
                stalled = 1'b1;
            end else if (stall > 0) begin
                stall--;
            end else begin
                bif.rdReady = 1'b1;
            end
            step(1);
            b++;
        end
        bif.rdReady = 1'b1;
        rd_gate_en = 1'b0;
        chk("rd_rsp_seen", 72'(n_rsp != s0), 72'd1);
        chk("rd_stall_done", 72'(stalled), 72'd1);
        chk("rd_cmd_word", last_cmd, 72'h02_46_00000000000200);
        chk("rd_words_before_rsp", 72'(rsp_rd_cnt), 72'd128);
        chk("rd_word_cnt", 72'(got_rd.size()), 72'd128);
        chk("rd_fifo_reads", 72'(n_rdat_rd - d0), 72'd128);
        for (int i = 0; i < 128 && i < int'(got_rd.size()); i++)
            chk($sformatf("rd_w%0d", i), 72'(got_rd[i]), 72'(mkrd(i)));
        chk("rd_status", 72'(last_status), 72'h9_0000_0900);
        chk("rd_timeout_flag", 72'(last_to), 72'd0);

        // Result never arrives: timeout decided in the 100th WAIT cycle, pulse seen the next cycle
        r0 = n_res_rd; s0 = n_rsp;
        do_req(6'd0, 2'b00, 8'd0, 32'h0);
        wait_rsp(s0, 300, "to_rsp_seen");
        step(2);
        chk("to_latency", 72'(rsp_cyc - cmd_cyc), 72'd101);
        chk("to_flag", 72'(last_to), 72'd1);
        chk("to_status", 72'(last_status), 72'd0);
        chk("to_rsp_cnt", 72'(n_rsp - s0), 72'd1);
        chk("to_no_res_rd", 72'(n_res_rd - r0), 72'd0);
        chk("to_ready_after", 72'(bif.reqReady), 72'd1);

        // Reset in the middle of a write phase
        got_wr.delete();
        do_req(6'd24, 2'b01, 8'd1, 32'h0000_2000);
        feed(10, -1, ok);
        chk("rst_mid_feed", 72'(got_wr.size()), 72'd10);
        chk("rst_mid_busy", 72'(bif.busy), 72'd1);
        bif.wrValid = 1'b1;
        #2;
        sysRst = 1'b1;
        #1;
        chk("rst_mid_ready", 72'(bif.reqReady), 72'd0);
        chk("rst_mid_busy0", 72'(bif.busy), 72'd0);
        chk("rst_mid_wrready", 72'(bif.wrReady), 72'd0);
        chk("rst_mid_strobe", 72'(bif.cmdDataFifoWrEn), 72'd0);
        chk("rst_mid_wdata", bif.cmdDataFifoData, 72'd0);
        chk("rst_mid_cmd_data", bif.cmdFifoData, 72'd0);
        chk("rst_mid_status", 72'(bif.rspStatus), 72'd0);
        chk("rst_mid_rd_data", 72'(bif.rdData), 72'd0);
        bif.wrValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sysRst = 1'b0;
        step(1);
        chk("rst_mid_ready_back", 72'(bif.reqReady), 72'd1);
        n0 = n_cmd; s0 = n_rsp;
        do_req(6'd0, 2'b00, 8'd0, 32'h0);
        res_word = 36'h0_0000_0555;
        step(4);
        bif.resultPending = 1'b1;
        wait_rsp(s0, 50, "post_rst_rsp_seen");
        chk("post_rst_cmd_cnt", 72'(n_cmd - n0), 72'd1);
        chk("post_rst_cmd_word", last_cmd, 72'h0);
        chk("post_rst_status", 72'(last_status), 72'h555);
        chk("post_rst_timeout_flag", 72'(last_to), 72'd0);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
